// File: rtl/mem_dreq_ctrl_if.sv
// SRAM-like data bus between the MEM-stage request controller (master) and data memory (slave).
interface mem_dreq_ctrl_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_dreq_ctrl.sv
// MEM-stage data-memory request controller: one outstanding req/addr_ok/data_ok transaction per load/store.
// Optional watchdog on outstanding requests enabled by defining MEM_DREQ_TIMEOUT_EN.
module mem_dreq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            mem_en_i,
    input  logic            mem_wr_i,
    input  logic [1:0]      mem_size_i,
    input  logic            mem_sext_i,
    input  logic [31:0]     mem_addr_i,
    input  logic [31:0]     mem_wdata_i,
    mem_dreq_ctrl_if.master bus,
    output logic            stallreq_o,
    output logic [31:0]     rdata_o,
    output logic            done_o,
    output logic            excp_adel_o,
    output logic            excp_ades_o,
    output logic            bus_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [3:0] store_strb(input logic wr, input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        if (!wr) begin
            s = 4'b0000;
        end else begin
            case (size)
                2'd0:    s = 4'b0001 << a;
                2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
                default: s = 4'b1111;
            endcase
        end
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'd0:    r = {4{d[7:0]}};
            2'd1:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic sext,
                                             input logic [1:0] a, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (size)
            2'd0:    r = {{24{sext & b[7]}}, b};
            2'd1:    r = {{16{sext & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        misalign_s;
    logic        go_s;

    assign misalign_s  = ((mem_size_i == 2'd1) & mem_addr_i[0]) |
                         ((mem_size_i >= 2'd2) & (mem_addr_i[1:0] != 2'd0));
    assign excp_adel_o = mem_en_i & ~mem_wr_i & misalign_s;
    assign excp_ades_o = mem_en_i &  mem_wr_i & misalign_s;
    assign go_s        = mem_en_i & ~misalign_s & ~flush;

    assign stallreq_o  = ((state_q == ST_IDLE) & go_s) | (state_q == ST_REQ) |
                         (state_q == ST_WAIT) | (state_q == ST_DRAIN);

    assign bus.data_sram_req   = req_q;
    assign bus.data_sram_wr    = wr_q;
    assign bus.data_sram_size  = size_q;
    assign bus.data_sram_addr  = addr_q;
    assign bus.data_sram_wstrb = wstrb_q;
    assign bus.data_sram_wdata = wdata_q;
    assign rdata_o             = rdata_q;
    assign done_o              = done_q;

`ifdef MEM_DREQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    logic [15:0] cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;
    assign bus_err_o = bus_err_q;
`else
    assign bus_err_o = 1'b0;
`endif

    // Next-state, request latching and result capture.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wr_d    = wr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_s) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    wr_d    = mem_wr_i;
                    size_d  = mem_size_i;
                    sext_d  = mem_sext_i;
                    addr_d  = mem_addr_i;
                    wstrb_d = store_strb(mem_wr_i, mem_size_i, mem_addr_i[1:0]);
                    wdata_d = store_data(mem_size_i, mem_wdata_i);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.data_sram_addr_ok) begin
                    req_d   = 1'b0;
                    state_d = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A flush racing data_ok means the response is already consumed; nothing left to drain.
                if (flush) begin
                    state_d = bus.data_sram_data_ok ? ST_IDLE : ST_DRAIN;
                end else if (bus.data_sram_data_ok) begin
                    rdata_d = wr_q ? 32'd0 : load_fmt(size_q, sext_q, addr_q[1:0], bus.data_sram_rdata);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (bus.data_sram_data_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
`ifdef MEM_DREQ_TIMEOUT_EN
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_d = 16'd0;
        end else if ((state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAIN)) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == TO_LAST) begin
                state_d   = ST_IDLE;
                req_d     = 1'b0;
                done_d    = 1'b0;
                rdata_d   = rdata_q;
                bus_err_d = 1'b1;
                cnt_d     = 16'd0;
            end else begin
                bus_err_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

`ifdef MEM_DREQ_TIMEOUT_EN
    // Watchdog counter and expiry pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 16'd0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_dreq_ctrl.sv
// Directed, table-driven bench for mem_dreq_ctrl plus hand-written multi-cycle sequences.
module tb_mem_dreq_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        mem_en;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic        mem_sext;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stallreq;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        adel;
    logic        ades;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_dreq_ctrl_if sram_if ();

    mem_dreq_ctrl #(.TIMEOUT_CYCLES(32'd8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .mem_en_i    (mem_en),
        .mem_wr_i    (mem_wr),
        .mem_size_i  (mem_size),
        .mem_sext_i  (mem_sext),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .bus         (sram_if),
        .stallreq_o  (stallreq),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .excp_adel_o (adel),
        .excp_ades_o (ades),
        .bus_err_o   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_adel;
        logic        exp_ades;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic wr, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata);
        mem_en    = 1'b1;
        mem_wr    = wr;
        mem_size  = size;
        mem_sext  = sext;
        mem_addr  = addr;
        mem_wdata = wdata;
    endtask

    function automatic vec_t mk(input string nm, input logic wr, input logic [1:0] size, input logic sext,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] brd,
                                input logic [31:0] erd, input logic [3:0] estrb, input logic [31:0] ewd,
                                input logic eadel, input logic eades);
        vec_t v;
        v.name = nm; v.wr = wr; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
        v.bus_rdata = brd; v.exp_rdata = erd; v.exp_wstrb = estrb; v.exp_wdata = ewd;
        v.exp_adel = eadel; v.exp_ades = eades;
        return v;
    endfunction

    // Zero-wait transaction: addr_ok in cycle 1, data_ok in cycle 2, done in cycle 3.
    task automatic run_vec(input vec_t v);
        logic mis;
        mis = v.exp_adel | v.exp_ades;
        set_op(v.wr, v.size, v.sext, v.addr, v.wdata);
        @(negedge clk);
        chk1({v.name, "/adel"}, adel, v.exp_adel);
        chk1({v.name, "/ades"}, ades, v.exp_ades);
        chk1({v.name, "/stall0"}, stallreq, ~mis);
        step();
        if (mis) begin
            mem_en = 1'b0;
            @(negedge clk);
            chk1({v.name, "/noreq"}, sram_if.data_sram_req, 1'b0);
            chk1({v.name, "/nostall"}, stallreq, 1'b0);
            step();
        end else begin
            sram_if.data_sram_addr_ok = 1'b1;
            @(negedge clk);
            chk1({v.name, "/req1"}, sram_if.data_sram_req, 1'b1);
            chk1({v.name, "/wr"}, sram_if.data_sram_wr, v.wr);
            chk({v.name, "/addr"}, sram_if.data_sram_addr, v.addr);
            chk({v.name, "/size"}, {30'd0, sram_if.data_sram_size}, {30'd0, v.size});
            chk({v.name, "/wstrb"}, {28'd0, sram_if.data_sram_wstrb}, {28'd0, v.exp_wstrb});
            if (v.wr) chk({v.name, "/wdata"}, sram_if.data_sram_wdata, v.exp_wdata);
            chk1({v.name, "/stall1"}, stallreq, 1'b1);
            step();
            sram_if.data_sram_addr_ok = 1'b0;
            sram_if.data_sram_data_ok = 1'b1;
            sram_if.data_sram_rdata   = v.bus_rdata;
            @(negedge clk);
            chk1({v.name, "/req2"}, sram_if.data_sram_req, 1'b0);
            chk1({v.name, "/stall2"}, stallreq, 1'b1);
            chk1({v.name, "/done2"}, done_o, 1'b0);
            step();
            sram_if.data_sram_data_ok = 1'b0;
            sram_if.data_sram_rdata   = 32'd0;
            @(negedge clk);
            chk1({v.name, "/done3"}, done_o, 1'b1);
            chk({v.name, "/rdata"}, rdata_o, v.exp_rdata);
            chk1({v.name, "/stall3"}, stallreq, 1'b0);
            step();
            mem_en = 1'b0;
            @(negedge clk);
            chk1({v.name, "/done4"}, done_o, 1'b0);
            chk1({v.name, "/stall4"}, stallreq, 1'b0);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'd0;
        mem_sext = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b0;
        sram_if.data_sram_rdata   = 32'd0;

        vecs.push_back(mk("lw",    1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0000, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk("lb",    1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'b0000, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk("lbu",   1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 32'h0000_0080, 4'b0000, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk("lh",    1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'd0, 32'h8001_1234, 32'hFFFF_8001, 4'b0000, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk("lhu",   1'b0, 2'd1, 1'b0, 32'h0000_1000, 32'd0, 32'h8001_F234, 32'h0000_F234, 4'b0000, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk("lb1",   1'b0, 2'd0, 1'b1, 32'h0000_1001, 32'd0, 32'h0000_7F00, 32'h0000_007F, 4'b0000, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk("lw_s3", 1'b0, 2'd3, 1'b0, 32'h0000_1008, 32'd0, 32'h0102_0304, 32'h0102_0304, 4'b0000, 32'd0, 1'b0, 1'b0));
        vecs.push_back(mk("sb1",   1'b1, 2'd0, 1'b0, 32'h0000_2001, 32'h1234_56AB, 32'hFFFF_FFFF, 32'd0, 4'b0010, 32'hABAB_ABAB, 1'b0, 1'b0));
        vecs.push_back(mk("sb3",   1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00C3, 32'hFFFF_FFFF, 32'd0, 4'b1000, 32'hC3C3_C3C3, 1'b0, 1'b0));
        vecs.push_back(mk("sh0",   1'b1, 2'd1, 1'b0, 32'h0000_2000, 32'h1234_5678, 32'hFFFF_FFFF, 32'd0, 4'b0011, 32'h5678_5678, 1'b0, 1'b0));
        vecs.push_back(mk("sw",    1'b1, 2'd2, 1'b0, 32'h0000_2004, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'd0, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0));
        vecs.push_back(mk("lw_mis",1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'd0, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b1, 1'b0));
        vecs.push_back(mk("sw_mis",1'b1, 2'd2, 1'b0, 32'h0000_1001, 32'd0, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b0, 1'b1));
        vecs.push_back(mk("lh_mis",1'b0, 2'd1, 1'b1, 32'h0000_1001, 32'd0, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b1, 1'b0));
        vecs.push_back(mk("sh_mis",1'b1, 2'd1, 1'b0, 32'h0000_1003, 32'd0, 32'd0, 32'd0, 4'b0000, 32'd0, 1'b0, 1'b1));

        // Reset state.
        #3;
        chk1("rst/req", sram_if.data_sram_req, 1'b0);
        chk1("rst/wr", sram_if.data_sram_wr, 1'b0);
        chk("rst/addr", sram_if.data_sram_addr, 32'd0);
        chk("rst/wstrb", {28'd0, sram_if.data_sram_wstrb}, 32'd0);
        chk("rst/wdata", sram_if.data_sram_wdata, 32'd0);
        chk("rst/rdata", rdata_o, 32'd0);
        chk1("rst/done", done_o, 1'b0);
        chk1("rst/bus_err", bus_err, 1'b0);
        chk1("rst/stall", stallreq, 1'b0);
        #9;
        rst = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // SH with addr_ok held off: request fields must stay stable for 4 cycles.
        set_op(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_5678);
        step();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) sram_if.data_sram_addr_ok = 1'b1;
            @(negedge clk);
            chk1($sformatf("sh_slow/req%0d", k), sram_if.data_sram_req, 1'b1);
            chk($sformatf("sh_slow/addr%0d", k), sram_if.data_sram_addr, 32'h0000_2002);
            chk($sformatf("sh_slow/wstrb%0d", k), {28'd0, sram_if.data_sram_wstrb}, 32'h0000_000C);
            chk($sformatf("sh_slow/wdata%0d", k), sram_if.data_sram_wdata, 32'h5678_5678);
            chk1($sformatf("sh_slow/stall%0d", k), stallreq, 1'b1);
            step();
        end
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b1;
        @(negedge clk);
        chk1("sh_slow/req_off", sram_if.data_sram_req, 1'b0);
        step();
        sram_if.data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk1("sh_slow/done", done_o, 1'b1);
        step();
        mem_en = 1'b0;

        // Flush in WAIT, orphan data_ok two cycles later, then a new LW.
        set_op(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'd0);
        step();
        sram_if.data_sram_addr_ok = 1'b1;
        step();
        sram_if.data_sram_addr_ok = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk1("drain/stall_c2", stallreq, 1'b1);
        step();
        flush = 1'b0;
        set_op(1'b0, 2'd2, 1'b0, 32'h0000_3004, 32'd0);
        @(negedge clk);
        chk1("drain/stall_c3", stallreq, 1'b1);
        chk1("drain/req_c3", sram_if.data_sram_req, 1'b0);
        chk1("drain/done_c3", done_o, 1'b0);
        step();
        sram_if.data_sram_data_ok = 1'b1;
        sram_if.data_sram_rdata   = 32'h2222_2222;
        @(negedge clk);
        chk1("drain/stall_c4", stallreq, 1'b1);
        chk1("drain/req_c4", sram_if.data_sram_req, 1'b0);
        step();
        sram_if.data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk1("drain/stall_c5", stallreq, 1'b1);
        chk1("drain/req_c5", sram_if.data_sram_req, 1'b0);
        chk1("drain/done_c5", done_o, 1'b0);
        step();
        sram_if.data_sram_addr_ok = 1'b1;
        @(negedge clk);
        chk1("drain/req_c6", sram_if.data_sram_req, 1'b1);
        chk("drain/addr_c6", sram_if.data_sram_addr, 32'h0000_3004);
        chk1("drain/done_c6", done_o, 1'b0);
        step();
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b1;
        sram_if.data_sram_rdata   = 32'h3333_3333;
        step();
        sram_if.data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk1("drain/done_c8", done_o, 1'b1);
        chk("drain/rdata_c8", rdata_o, 32'h3333_3333);
        step();
        mem_en = 1'b0;

        // Flush in REQ without addr_ok cancels the request.
        set_op(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk1("req_flush/stall", stallreq, 1'b1);
        step();
        flush = 1'b0;
        mem_en = 1'b0;
        @(negedge clk);
        chk1("req_flush/req", sram_if.data_sram_req, 1'b0);
        chk1("req_flush/stall_after", stallreq, 1'b0);
        step();

        // Flush from IDLE with an op present, and stray data_ok in IDLE.
        set_op(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'd0);
        flush = 1'b1;
        sram_if.data_sram_data_ok = 1'b1;
        @(negedge clk);
        chk1("idle_flush/stall", stallreq, 1'b0);
        step();
        flush = 1'b0;
        mem_en = 1'b0;
        sram_if.data_sram_data_ok = 1'b0;
        @(negedge clk);
        chk1("idle_flush/req", sram_if.data_sram_req, 1'b0);
        chk1("idle_flush/done", done_o, 1'b0);
        step();

        // Asynchronous reset in the middle of WAIT.
        set_op(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'd0);
        step();
        sram_if.data_sram_addr_ok = 1'b1;
        step();
        sram_if.data_sram_addr_ok = 1'b0;
        #1;
        rst = 1'b0;
        mem_en = 1'b0;
        #1;
        chk1("arst/req", sram_if.data_sram_req, 1'b0);
        chk("arst/addr", sram_if.data_sram_addr, 32'd0);
        chk("arst/rdata", rdata_o, 32'd0);
        chk1("arst/done", done_o, 1'b0);
        chk1("arst/stall", stallreq, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

`ifdef MEM_DREQ_TIMEOUT_EN
        // Watchdog: addr_ok never arrives; 8 cycles in REQ, then bus_err and back to IDLE.
        set_op(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'd0);
        step();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk1($sformatf("tmo/req_c%0d", k), sram_if.data_sram_req, 1'b1);
            chk1($sformatf("tmo/err_c%0d", k), bus_err, 1'b0);
            step();
        end
        mem_en = 1'b0;
        @(negedge clk);
        chk1("tmo/err_pulse", bus_err, 1'b1);
        chk1("tmo/req_drop", sram_if.data_sram_req, 1'b0);
        chk1("tmo/stall_drop", stallreq, 1'b0);
        step();
        @(negedge clk);
        chk1("tmo/err_clear", bus_err, 1'b0);
        step();
`else
        @(negedge clk);
        chk1("no_tmo/bus_err", bus_err, 1'b0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
